// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point multiplier: rounding modes,
// special-operand classes, flag bit positions and format constant functions.
package fp_pkg;

    typedef enum logic {
        RM_RNE = 1'b0,
        RM_RTZ = 1'b1
    } rm_e;

    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_ZERO = 2'd1,
        SP_INF  = 2'd2,
        SP_NAN  = 2'd3
    } special_e;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // Upper bound on exponent+fraction width for the magnitude helpers below.
    localparam int FP_MAX_W = 128;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_inf_mag(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w+i] = 1'b1;
        return v;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_max_mag(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = fp_inf_mag(exp_w, man_w);
        v[man_w] = 1'b0;
        for (int i = 0; i < man_w; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = fp_inf_mag(exp_w, man_w);
        v[man_w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Final multiplier stage logic: normalize the raw significand product, round it,
// resolve special cases / overflow / underflow and pack the result word.
module fp_mul_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [2*MAN_W+1:0]   prod,
    input  logic [EXP_W+1:0]     exp_in,
    input  logic                 sign,
    input  logic                 rm,
    input  logic [1:0]           kind,
    output logic [EXP_W+MAN_W:0] out,
    output logic [3:0]           flags
);

    localparam int PW = 2 * (MAN_W + 1);

    localparam logic [EXP_W+MAN_W-1:0] INF_MAG = (EXP_W+MAN_W)'(fp_inf_mag(EXP_W, MAN_W));
    localparam logic [EXP_W+MAN_W-1:0] MAX_MAG = (EXP_W+MAN_W)'(fp_max_mag(EXP_W, MAN_W));
    localparam logic [EXP_W+MAN_W:0]   QNAN    = (EXP_W+MAN_W+1)'(fp_qnan(EXP_W, MAN_W));
    localparam logic signed [EXP_W+1:0] EXP_ALL1 = (EXP_W+2)'(fp_exp_max(EXP_W));

    logic [PW-1:0]           norm;
    logic signed [EXP_W+1:0] exp_n;
    logic signed [EXP_W+1:0] exp_r;
    logic [MAN_W:0]          kept;
    logic                    guard;
    logic                    sticky;
    logic                    inc;
    logic [MAN_W+1:0]        rnd;
    logic                    carry;
    logic [MAN_W-1:0]        frac;
    logic                    ovf;
    logic                    unf;

    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        out   = '0;
        flags = '0;

        // Product of two [1,2) significands lies in [1,4); bring the leading one to the MSB.
        norm  = prod[PW-1] ? prod : {prod[PW-2:0], 1'b0};
        exp_n = $signed(exp_in) + $signed({{(EXP_W+1){1'b0}}, prod[PW-1]});

        kept   = norm[PW-1 -: MAN_W+1];
        guard  = norm[PW-MAN_W-2];
        sticky = |norm[PW-MAN_W-3:0];
        inc    = (rm == RM_RNE) && guard && (sticky || kept[0]);

        rnd   = {1'b0, kept} + {{(MAN_W+1){1'b0}}, inc};
        carry = rnd[MAN_W+1];
        frac  = carry ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        exp_r = exp_n + $signed({{(EXP_W+1){1'b0}}, carry});

        ovf = !exp_r[EXP_W+1] && (exp_r >= EXP_ALL1);
        unf = exp_r[EXP_W+1] || (exp_r == '0);

        case (special_e'(kind))
            SP_NAN: begin
                out                 = QNAN;
                flags[FLAG_INVALID] = 1'b1;
            end
            SP_INF:  out = {sign, INF_MAG};
            SP_ZERO: out = {sign, {(EXP_W+MAN_W){1'b0}}};
            default: begin
                flags[FLAG_INEXACT] = guard | sticky;
                if (ovf) begin
                    out                  = {sign, (rm == RM_RTZ) ? MAX_MAG : INF_MAG};
                    flags[FLAG_OVERFLOW] = 1'b1;
                    flags[FLAG_INEXACT]  = 1'b1;
                end else if (unf) begin
                    out                   = {sign, {(EXP_W+MAN_W){1'b0}}};
                    flags[FLAG_UNDERFLOW] = 1'b1;
                    flags[FLAG_INEXACT]   = 1'b1;
                end else begin
                    out = {sign, exp_r[EXP_W-1:0], frac};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_multiplier_pipe.sv
// Three-stage pipelined floating-point multiplier with a single global stall
// driven by output backpressure; subnormals are flushed to signed zero.
module fp_multiplier_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 rm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out,
    output logic [3:0]           flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * (MAN_W + 1);
    localparam logic [EXP_W+1:0] BIAS     = (EXP_W+2)'(fp_bias(EXP_W));
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    logic advance;

    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [MAN_W-1:0] fa;
    logic [MAN_W-1:0] fb;
    logic             a_zero, a_inf, a_nan;
    logic             b_zero, b_inf, b_nan;
    special_e         kind_c;

    logic             s1_valid;
    logic             s1_sign;
    logic [EXP_W+1:0] s1_exp;
    logic [MAN_W:0]   s1_ma;
    logic [MAN_W:0]   s1_mb;
    special_e         s1_kind;
    logic             s1_rm;

    logic             s2_valid;
    logic             s2_sign;
    logic [EXP_W+1:0] s2_exp;
    logic [PW-1:0]    s2_prod;
    special_e         s2_kind;
    logic             s2_rm;

    logic [W-1:0]     rnd_out;
    logic [3:0]       rnd_flags;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign ea = a[W-2:MAN_W];
    assign eb = b[W-2:MAN_W];
    assign fa = a[MAN_W-1:0];
    assign fb = b[MAN_W-1:0];

    // A zero exponent field covers both true zero and flushed subnormals.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);

    always_comb begin
        kind_c = SP_NONE;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            kind_c = SP_NAN;
        else if (a_inf || b_inf)
            kind_c = SP_INF;
        else if (a_zero || b_zero)
            kind_c = SP_ZERO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out   <= rnd_out;
                flags <= rnd_flags;
            end
        end
    end

    // NOTE: stage data registers carry no reset; they are qualified by the valid bits above.
    always_ff @(posedge clk) begin
        if (advance && in_valid) begin
            s1_sign <= a[W-1] ^ b[W-1];
            s1_exp  <= {2'b00, ea} + {2'b00, eb} - BIAS;
            s1_ma   <= {1'b1, fa};
            s1_mb   <= {1'b1, fb};
            s1_kind <= kind_c;
            s1_rm   <= rm;
        end
        if (advance && s1_valid) begin
            s2_prod <= {{(MAN_W+1){1'b0}}, s1_ma} * {{(MAN_W+1){1'b0}}, s1_mb};
            s2_sign <= s1_sign;
            s2_exp  <= s1_exp;
            s2_kind <= s1_kind;
            s2_rm   <= s1_rm;
        end
    end

    fp_mul_round #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round (
        .prod   (s2_prod),
        .exp_in (s2_exp),
        .sign   (s2_sign),
        .rm     (s2_rm),
        .kind   (s2_kind),
        .out    (rnd_out),
        .flags  (rnd_flags)
    );

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Self-checking bench for fp_multiplier_pipe (binary32): directed vectors,
// randomized traffic against an arithmetic reference model, stalls and reset.
module tb_fp_multiplier_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    fp_multiplier_pipe #(
        .EXP_W(8),
        .MAN_W(23)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [35:0] exp_q[$];

    logic        obs_in_fire;
    logic        obs_out_fire;
    logic        obs_out_valid;
    logic [31:0] obs_out;
    logic [3:0]  obs_flags;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        rm;
        logic [31:0] o;
        logic [3:0]  f;
    } vec_t;

    // Reference: exact integer product, rounded by quotient/remainder arithmetic.
    function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic mode);
        int              ex, ey, e, sh;
        logic            s, inexact;
        logic            x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
        longint unsigned mx, my, p, q, r, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        x_zero = (ex == 0);
        y_zero = (ey == 0);
        x_inf  = (ex == 255) && (x[22:0] == 23'd0);
        y_inf  = (ey == 255) && (y[22:0] == 23'd0);
        x_nan  = (ex == 255) && (x[22:0] != 23'd0);
        y_nan  = (ey == 255) && (y[22:0] != 23'd0);
        if (x_nan || y_nan || (x_inf && y_zero) || (x_zero && y_inf))
            return {4'b1000, 32'h7FC00000};
        if (x_inf || y_inf)
            return {4'b0000, s, 31'h7F800000};
        if (x_zero || y_zero)
            return {4'b0000, s, 31'h0};
        mx = 64'h800000 | 64'(x[22:0]);
        my = 64'h800000 | 64'(y[22:0]);
        p  = mx * my;
        e  = ex + ey - 127;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        q    = p >> sh;
        r    = p - (q << sh);
        half = 64'd1 << (sh - 1);
        inexact = (r != 0);
        if (!mode && ((r > half) || ((r == half) && q[0])))
            q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255)
            return {4'b0101, s, mode ? 31'h7F7FFFFF : 31'h7F800000};
        if (e <= 0)
            return {4'b0011, s, 31'h0};
        return {3'b000, inexact, s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 15))
            0:       v[30:23] = 8'h00;
            1:       v[30:0]  = 31'h7F800000;
            2:       v[30:23] = 8'hFF;
            3:       v[30:23] = 8'($urandom_range(1, 254));
            4:       v[30:23] = 8'($urandom_range(1, 10));
            5:       v[30:23] = 8'($urandom_range(245, 254));
            6: begin
                v[30:23] = 8'($urandom_range(110, 140));
                v[22:0]  = '1;
            end
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // One clock: observe handshakes at negedge, score any output, log any input.
    task automatic step();
        logic [35:0] exp_e;
        @(negedge clk);
        obs_in_fire   = in_valid && in_ready;
        obs_out_fire  = out_valid && out_ready;
        obs_out_valid = out_valid;
        obs_out       = out;
        obs_flags     = flags;
        if (obs_out_fire) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_extra: got out=%h flags=%b, want no result", out, flags);
            end else begin
                exp_e = exp_q.pop_front();
                if ({flags, out} !== exp_e)
                    $display("FAIL scoreboard: got out=%h flags=%b, want out=%h flags=%b",
                             out, flags, exp_e[31:0], exp_e[35:32]);
                else
                    n_pass++;
            end
        end
        if (obs_in_fire)
            exp_q.push_back(ref_mul(a, b, rm));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        rm        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out !== 32'h0) $display("FAIL reset_out: got %h want 00000000", out);
        else n_pass++;
        n_checks++;
        if (flags !== 4'h0) $display("FAIL reset_flags: got %b want 0000", flags);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        vec_t vecs[12];
        logic acc, early;
        vecs[0]  = '{32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
        vecs[1]  = '{32'hBFC00000, 32'h40000000, 1'b0, 32'hC0400000, 4'b0000};
        vecs[2]  = '{32'h3FC00001, 32'h3FC00001, 1'b0, 32'h40100002, 4'b0001};
        vecs[3]  = '{32'h3FC00001, 32'h3FC00001, 1'b1, 32'h40100001, 4'b0001};
        vecs[4]  = '{32'h7F7FFFFF, 32'h40000000, 1'b0, 32'h7F800000, 4'b0101};
        vecs[5]  = '{32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F7FFFFF, 4'b0101};
        vecs[6]  = '{32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[7]  = '{32'h00400000, 32'h40000000, 1'b0, 32'h00000000, 4'b0000};
        vecs[8]  = '{32'h7F800000, 32'hC0000000, 1'b0, 32'hFF800000, 4'b0000};
        vecs[9]  = '{32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 4'b0011};
        vecs[10] = '{32'h80000000, 32'h3F800000, 1'b0, 32'h80000000, 4'b0000};
        vecs[11] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a        = vecs[i].a;
            b        = vecs[i].b;
            rm       = vecs[i].rm;
            in_valid = 1'b1;
            step();
            acc      = obs_in_fire;
            in_valid = 1'b0;
            step();
            early = obs_out_valid;
            step();
            early = early | obs_out_valid;
            step();
            n_checks++;
            if (!acc || early || !obs_out_valid)
                $display("FAIL latency_%0d: got accepted=%b early=%b valid_at_3=%b, want 1/0/1",
                         i, acc, early, obs_out_valid);
            else
                n_pass++;
            n_checks++;
            if ({obs_flags, obs_out} !== {vecs[i].f, vecs[i].o})
                $display("FAIL directed_%0d: got out=%h flags=%b, want out=%h flags=%b",
                         i, obs_out, obs_flags, vecs[i].o, vecs[i].f);
            else
                n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            a         = rand_op();
            b         = rand_op();
            rm        = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL random_drain: got %0d pending, want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int          acc_cnt;
        int          fire_cnt;
        logic [35:0] held;
        logic        stable;
        acc_cnt   = 0;
        stable    = 1'b1;
        held      = '0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a  = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
            b  = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
            rm = 1'($urandom_range(0, 1));
            step();
            if (obs_in_fire) acc_cnt++;
            if (i == 3) held = {obs_flags, obs_out};
            if (i == 4 && {obs_flags, obs_out} !== held) stable = 1'b0;
        end
        n_checks++;
        if (acc_cnt != 3) $display("FAIL stall_accept_count: got %0d want 3", acc_cnt);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step();
            if ({obs_flags, obs_out} !== held || !obs_out_valid) stable = 1'b0;
        end
        n_checks++;
        if (!stable) $display("FAIL stall_out_stable: got out=%h want held out=%h", obs_out, held[31:0]);
        else n_pass++;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fire_cnt  = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (obs_out_fire) fire_cnt++;
        end
        n_checks++;
        if (fire_cnt != 3) $display("FAIL release_consecutive: got %0d results in 3 cycles want 3", fire_cnt);
        else n_pass++;
        step();
        n_checks++;
        if (obs_out_valid !== 1'b0) $display("FAIL release_empty: got out_valid=%b want 0", obs_out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        int fire_cnt;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 32'h3F800000;
        b = 32'h40400000;
        step();
        a = 32'h40000000;
        step();
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL midflight_progress: got out_valid=%b want 1", out_valid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out !== 32'h0)
            $display("FAIL reset_immediate: got out_valid=%b out=%h want 0/00000000", out_valid, out);
        else
            n_pass++;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fire_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_out_fire) fire_cnt++;
        end
        n_checks++;
        if (fire_cnt != 0) $display("FAIL reset_stale: got %0d results after reset want 0", fire_cnt);
        else n_pass++;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
